mem_2k_reader: RTL and testbench

MEM_2K_READER -- requirements
Module: mem_2k_reader

---
 rtl/mem_2k_reader.sv | 159 +++++++++++++++
 tb/tb_mem_2k_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_2k_reader.sv
// rtl/mem_2k_reader.sv - burst reader from a 2K-word registered RAM into a ready/valid stream
// Optional macro MEM_2K_READER_STATS_EN enables the rd_words delivered-word counter.
module mem_2k_reader #(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 11,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              rdclock,
   input  logic              sclr,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rdaddress,
   input  logic [DATA_W-1:0] q,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       rd_words
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
   localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                 state;
   logic                   issued;
   logic [RD_LATENCY-1:0]  tag_sr;
   logic [ADDR_W:0]        remaining;
   logic [ADDR_W:0]        pending;
   logic                   zero_done;

   logic [DATA_W-1:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W:0]         fifo_count;

   logic [CNT_W-1:0]       inflight;
   logic [ADDR_W:0]        clamped;
   logic                   push;
   logic                   pop;
   logic                   last_pop;
   logic                   can_issue;

   // The address register itself counts as one in-flight read, ahead of the tag pipe.
   always_comb begin
      inflight = CNT_W'(issued);
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CNT_W'(tag_sr[i]);
      end
   end

   assign out_valid = (fifo_count != '0);
   assign out_data  = fifo_mem[rd_ptr];
   assign pop       = out_valid && out_ready;
   assign push      = tag_sr[RD_LATENCY-1];
   assign last_pop  = pop && (state != IDLE) && (pending == LEN_ONE);
   assign done      = zero_done || last_pop;
   assign busy      = (state != IDLE);
   assign clamped   = (length > MAX_LEN) ? MAX_LEN : length;

   // A pop this cycle frees a slot, so it counts as credit for a new issue.
   assign can_issue = (CNT_W'(fifo_count) + inflight) < (CNT_W'(FIFO_DEPTH) + CNT_W'(pop));

   always_ff @(posedge rdclock) begin
      if (sclr) begin
         state      <= IDLE;
         issued     <= 1'b0;
         tag_sr     <= '0;
         remaining  <= '0;
         pending    <= '0;
         zero_done  <= 1'b0;
         rdaddress  <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         zero_done <= 1'b0;
         issued    <= 1'b0;
         tag_sr[0] <= issued;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_sr[i] <= tag_sr[i-1];
         end

         if (push) begin
            fifo_mem[wr_ptr] <= q;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            fifo_count <= fifo_count + (PTR_W+1)'(1);
         end else if (!push && pop) begin
            fifo_count <= fifo_count - (PTR_W+1)'(1);
         end
         if (pop && state != IDLE) begin
            pending <= pending - LEN_ONE;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  if (clamped == '0) begin
                     zero_done <= 1'b1;
                  end else begin
                     rdaddress <= base_addr;
                     issued    <= 1'b1;
                     remaining <= clamped - LEN_ONE;
                     pending   <= clamped;
                     state     <= (clamped == LEN_ONE) ? DRAIN : READ;
                  end
               end
            end
            READ: begin
               if (can_issue) begin
                  rdaddress <= rdaddress + ADDR_ONE;
                  issued    <= 1'b1;
                  remaining <= remaining - LEN_ONE;
                  if (remaining == LEN_ONE) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (last_pop) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_2K_READER_STATS_EN
   logic [31:0] word_cnt;

   always_ff @(posedge rdclock) begin
      if (sclr) begin
         word_cnt <= '0;
      end else if (pop && word_cnt != 32'hFFFF_FFFF) begin
         word_cnt <= word_cnt + 32'd1;
      end
   end

   assign rd_words = word_cnt;
`else
   assign rd_words = 32'd0;
`endif

endmodule

// File: tb/tb_mem_2k_reader.sv
// tb/tb_mem_2k_reader.sv - scoreboard bench for mem_2k_reader with a registered RAM model
module tb_mem_2k_reader;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 11;
   localparam int DEPTH  = 4;
   localparam int NWORDS = 2048;

   logic              clk = 1'b0;
   logic              sclr = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   length = '0;
   logic              out_ready = 1'b1;
   logic [DATA_W-1:0] q = '0;
   wire               busy, done, out_valid;
   wire [ADDR_W-1:0]  rdaddress;
   wire [DATA_W-1:0]  out_data;
   wire [31:0]        rd_words;

   mem_2k_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LATENCY(2), .FIFO_DEPTH(DEPTH)) dut (
      .rdclock(clk), .sclr(sclr), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .rdaddress(rdaddress), .q(q), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .rd_words(rd_words));

   always #5 clk = ~clk;

   logic [DATA_W-1:0] ram [NWORDS];
   logic [ADDR_W-1:0] ram_a;
   always @(posedge clk) begin
      ram_a <= rdaddress;
      q     <= ram[ram_a];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   typedef struct {
      logic [DATA_W-1:0] data;
      bit                last;
      bit                zero;
   } exp_t;
   exp_t exp_q[$];

   int burst_base = 0, burst_len = 0, issued_k = 0, delivered = 0;
   bit rdy_rand = 1'b0;

   always @(posedge clk) begin
      if (rdy_rand) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: order/exactness of words, done timing, address sequence, backpressure bounds.
   bit prev_hold = 1'b0;
   logic [DATA_W-1:0] prev_data;
   always @(negedge clk) begin
      exp_t it;
      if (sclr) begin
         exp_q.delete();
         issued_k  = 0;
         delivered = 0;
         burst_len = 0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, prev_data);
         end
         if (busy) begin
            if (issued_k < burst_len && rdaddress == ADDR_W'(burst_base + issued_k))
               issued_k++;
            chk("addr_seq", (issued_k > 0) && rdaddress == ADDR_W'(burst_base + issued_k - 1), 1'b1);
            chk("outstanding_le_depth", (issued_k - delivered) <= DEPTH, 1'b1);
         end
         if (out_valid && out_ready) begin
            chk("word_expected", (exp_q.size() != 0) && !exp_q[0].zero, 1'b1);
            if (exp_q.size() != 0 && !exp_q[0].zero) begin
               it = exp_q.pop_front();
               chk("out_data", out_data, it.data);
               chk("done_on_last", done, it.last);
               delivered++;
            end
         end else if (done) begin
            chk("done_expected", (exp_q.size() != 0) && exp_q[0].zero, 1'b1);
            if (exp_q.size() != 0 && exp_q[0].zero) it = exp_q.pop_front();
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drives a start for one cycle (cycle 0) and returns in cycle 1.
   task automatic start_burst(input int base, input int len);
      int n;
      n = (len > NWORDS) ? NWORDS : len;
      burst_base = base;
      burst_len  = n;
      issued_k   = 0;
      delivered  = 0;
      if (n == 0) begin
         exp_q.push_back('{data: '0, last: 1'b0, zero: 1'b1});
      end
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{data: ram[(base + i) % NWORDS], last: (i == n - 1), zero: 1'b0});
      end
      base_addr = ADDR_W'(base);
      length    = (ADDR_W+1)'(len);
      start     = 1'b1;
      next_cycle();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int c;
      c = 0;
      while (!(exp_q.size() == 0 && !busy) && c < budget) begin
         next_cycle();
         c++;
      end
      chk("burst_complete_in_budget", c < budget, 1'b1);
   endtask

   task automatic do_reset();
      sclr = 1'b1;
      next_cycle();
      next_cycle();
      sclr = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ADDR_W-1:0] addr_before;
      logic [ADDR_W-1:0] wrap_exp [4];
      int base, len;

      for (int i = 0; i < NWORDS; i++) ram[i] = DATA_W'(i);

      // Reset with a concurrent start: reset must win.
      sclr = 1'b1; start = 1'b1; base_addr = 11'd9; length = 12'd4;
      next_cycle();
      start = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_rdaddress", rdaddress, 11'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_rd_words", rd_words, 32'd0);
      next_cycle();
      sclr = 1'b0;
      repeat (6) next_cycle();
      chk("sclr_beats_start", busy, 1'b0);

      // Basic latency: base=5 length=4, ready high.
      out_ready = 1'b1;
      start_burst(5, 4);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         chk($sformatf("lat_valid_c%0d", n), out_valid, (n >= 4 && n <= 7));
         chk($sformatf("lat_done_c%0d", n), done, (n == 7));
         chk($sformatf("lat_busy_c%0d", n), busy, (n <= 7));
         if (n == 1) chk("lat_addr_c1", rdaddress, 11'd5);
         next_cycle();
      end
      wait_idle(50);

      // Address wrap: 2046, 2047, 0, 1.
      wrap_exp[0] = 11'd2046; wrap_exp[1] = 11'd2047; wrap_exp[2] = 11'd0; wrap_exp[3] = 11'd1;
      start_burst(2046, 4);
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         chk($sformatf("wrap_addr_c%0d", n), rdaddress, wrap_exp[n-1]);
         next_cycle();
      end
      wait_idle(50);

      // Backpressure: ready low in cycles 3..12.
      start_burst(100, 16);
      for (int n = 1; n <= 14; n++) begin
         out_ready = !(n >= 3 && n <= 12);
         next_cycle();
      end
      out_ready = 1'b1;
      wait_idle(100);

      // Zero length.
      addr_before = rdaddress;
      start_burst(300, 0);
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         chk($sformatf("zl_done_c%0d", n), done, (n == 1));
         chk($sformatf("zl_valid_c%0d", n), out_valid, 1'b0);
         chk($sformatf("zl_busy_c%0d", n), busy, 1'b0);
         chk($sformatf("zl_addr_c%0d", n), rdaddress, addr_before);
         next_cycle();
      end
      wait_idle(10);

      // Reset mid-burst in cycle 6 of a length-10 burst.
      start_burst(40, 10);
      repeat (5) next_cycle();
      sclr = 1'b1;
      next_cycle();
      sclr = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      next_cycle();
      repeat (8) next_cycle();
      start_burst(0, 2);
      wait_idle(50);

      // Delivered-word counter over bursts of 3 and 5.
      do_reset();
      start_burst(700, 3);
      wait_idle(50);
      start_burst(1000, 5);
      wait_idle(50);
`ifdef MEM_2K_READER_STATS_EN
      chk("rd_words", rd_words, 32'd8);
`else
      chk("rd_words", rd_words, 32'd0);
`endif

      // Randomized bursts with random backpressure, clamped lengths and ignored starts.
      for (int i = 0; i < NWORDS; i++) ram[i] = {$urandom, $urandom};
      rdy_rand = 1'b1;
      for (int b = 0; b < 24; b++) begin
         base = $urandom_range(0, NWORDS - 1);
         case ($urandom_range(0, 11))
            0:       len = 0;
            1:       len = NWORDS + $urandom_range(0, 200);
            default: len = $urandom_range(1, 40);
         endcase
         start_burst(base, len);
         repeat ($urandom_range(0, 4)) next_cycle();
         if (busy) begin
            base_addr = ADDR_W'($urandom);
            length    = (ADDR_W+1)'($urandom_range(1, 20));
            start     = 1'b1;
            next_cycle();
            start = 1'b0;
         end
         wait_idle(6 * NWORDS + 100);
         next_cycle();
      end
      rdy_rand = 1'b0;
      next_cycle();
      chk("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
